// File: rtl/crc32_arb_pkg.sv
// ----------------------------------------------------------------------------
// crc32_arb_pkg
// Shared constants and types for the CRC32 stream arbiter slice.
//   CRC_W / CRC_INIT_DEFAULT : CRC seed width and the reset seed value
//   DEF_*                    : default parameter values for the arbiter
//   arb_state_e              : packet-level arbiter FSM state
// ----------------------------------------------------------------------------
package crc32_arb_pkg;

    localparam int unsigned       CRC_W            = 32;
    localparam logic [CRC_W-1:0]  CRC_INIT_DEFAULT = 32'hFFFF_FFFF;

    localparam int unsigned DEF_N_PORTS = 4;
    localparam int unsigned DEF_ID_W    = 2;
    localparam int unsigned DEF_DATA_W  = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/crc32_rr_pick.sv
// ----------------------------------------------------------------------------
// crc32_rr_pick
// Combinational rotate-priority picker. Searches req upward starting at
// (last+1) mod N_PORTS, wrapping, and returns the first requester found.
//   req   : per-port request mask
//   last  : previously granted port (lowest priority this round)
//   found : at least one request is present
//   pick  : chosen port (equals last when nothing is found)
// ----------------------------------------------------------------------------
module crc32_rr_pick
    import crc32_arb_pkg::*;
#(
    parameter int unsigned N_PORTS = DEF_N_PORTS,
    parameter int unsigned ID_W    = DEF_ID_W
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    pick
);

    // Request mask padded to the full index range so any ID_W index is legal.
    localparam int unsigned REQ_EXT_W = 1 << ID_W;

    logic [REQ_EXT_W-1:0] w_req_ext;
    logic [ID_W-1:0]      w_idx;

    assign w_req_ext = REQ_EXT_W'(req);

    // Walk from farthest to nearest so the nearest requester wins the last write.
    always_comb begin
        found = 1'b0;
        pick  = last;
        w_idx = '0;
        for (int i = int'(N_PORTS); i >= 1; i--) begin
            w_idx = ID_W'((int'(last) + i) % int'(N_PORTS));
            if (w_req_ext[w_idx]) begin
                found = 1'b1;
                pick  = w_idx;
            end
        end
    end

endmodule

// File: rtl/crc32_stream_arbiter.sv
// ----------------------------------------------------------------------------
// crc32_stream_arbiter
// Packet-granular round-robin arbiter sharing one CRC32 pipeline between
// N_PORTS AXI4-Stream requesters. Whole packets are forwarded without
// interleaving, every beat is tagged with its source port, and the granted
// port's CRC seed is held on m_crc_init for the whole packet.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_axis_t{data,keep,valid,last}  per-port requester streams (port p = slice p)
//   s_axis_tready                   per-port ready, only the granted port sees it
//   port_crc_init                   per-port CRC seeds
//   m_axis_t{data,keep,valid,last,id}, m_axis_tready
//                                   registered stream towards the CRC pipeline
//   m_crc_init                      seed of the granted port
//   grant_active, grant_id          packet in progress / current-or-last grant
//   pkt_count                       per-port completed-packet counters
//
// Build option: define CRC32_ARB_STATS_EN to build the per-port packet
// counters; otherwise pkt_count is tied to zero and no counter flops exist.
// ----------------------------------------------------------------------------
module crc32_stream_arbiter
    import crc32_arb_pkg::*;
#(
    parameter int unsigned N_PORTS = DEF_N_PORTS,
    parameter int unsigned ID_W    = DEF_ID_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [N_PORTS*DATA_W-1:0]     s_axis_tdata,
    input  logic [N_PORTS*(DATA_W/8)-1:0] s_axis_tkeep,
    input  logic [N_PORTS-1:0]            s_axis_tvalid,
    input  logic [N_PORTS-1:0]            s_axis_tlast,
    output logic [N_PORTS-1:0]            s_axis_tready,
    input  logic [N_PORTS*32-1:0]         port_crc_init,

    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic [(DATA_W/8)-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    output logic [ID_W-1:0]               m_axis_tid,
    input  logic                          m_axis_tready,
    output logic [31:0]                   m_crc_init,

    output logic                          grant_active,
    output logic [ID_W-1:0]               grant_id,
    output logic [N_PORTS*32-1:0]         pkt_count
);

    localparam int unsigned KEEP_W     = DATA_W / 8;
    localparam int unsigned PORT_EXT_W = 1 << ID_W;

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;

    logic [ID_W-1:0]       r_grant_id;
    logic [CRC_W-1:0]      r_crc_init;

    logic                  r_m_tvalid;
    logic                  r_m_tlast;
    logic [DATA_W-1:0]     r_m_tdata;
    logic [KEEP_W-1:0]     r_m_tkeep;
    logic [ID_W-1:0]       r_m_tid;

    logic                  w_found;
    logic [ID_W-1:0]       w_pick;
    logic                  w_out_ready;
    logic                  w_accept;
    logic                  w_load_grant;
    logic [PORT_EXT_W-1:0] w_tready_ext;

    logic [PORT_EXT_W-1:0] w_valid_ext;
    logic [PORT_EXT_W-1:0] w_last_ext;
    logic [DATA_W-1:0]     w_data [PORT_EXT_W];
    logic [KEEP_W-1:0]     w_keep [PORT_EXT_W];
    logic [CRC_W-1:0]      w_crc  [PORT_EXT_W];

    logic                  w_g_valid;
    logic                  w_g_last;

    // Unpack the flat per-port buses; entries beyond N_PORTS read as zero.
    for (genvar p = 0; p < int'(PORT_EXT_W); p++) begin : g_unpack
        if (p < int'(N_PORTS)) begin : g_real
            assign w_data[p] = s_axis_tdata[p*DATA_W +: DATA_W];
            assign w_keep[p] = s_axis_tkeep[p*KEEP_W +: KEEP_W];
            assign w_crc[p]  = port_crc_init[p*CRC_W +: CRC_W];
        end else begin : g_pad
            assign w_data[p] = '0;
            assign w_keep[p] = '0;
            assign w_crc[p]  = '0;
        end
    end

    assign w_valid_ext = PORT_EXT_W'(s_axis_tvalid);
    assign w_last_ext  = PORT_EXT_W'(s_axis_tlast);
    assign w_g_valid   = w_valid_ext[r_grant_id];
    assign w_g_last    = w_last_ext[r_grant_id];

    // Output register can take a new beat when empty or draining this cycle.
    assign w_out_ready = !r_m_tvalid || m_axis_tready;

    crc32_rr_pick #(
        .N_PORTS (N_PORTS),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (s_axis_tvalid),
        .last  (r_grant_id),
        .found (w_found),
        .pick  (w_pick)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_accept && w_g_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: grant load in IDLE, ready/accept for the granted port in BUSY.
    always_comb begin
        w_tready_ext = '0;
        w_accept     = 1'b0;
        w_load_grant = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_grant = w_found;
            end
            ST_BUSY: begin
                w_tready_ext[r_grant_id] = w_out_ready;
                w_accept                 = w_out_ready && w_g_valid;
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
    end

    assign s_axis_tready = w_tready_ext[N_PORTS-1:0];

    // Grant and seed registers: updated only when a new packet is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_id <= ID_W'(N_PORTS - 1);
            r_crc_init <= CRC_INIT_DEFAULT;
        end else if (w_load_grant) begin
            r_grant_id <= w_pick;
            r_crc_init <= w_crc[w_pick];
        end
    end

    // Output stage: loads on accept, otherwise empties once the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tid    <= '0;
        end else if (w_accept) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_g_last;
            r_m_tdata  <= w_data[r_grant_id];
            r_m_tkeep  <= w_keep[r_grant_id];
            r_m_tid    <= r_grant_id;
        end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

`ifdef CRC32_ARB_STATS_EN
    // Per-port counters of accepted tlast beats, wrapping at 2^32.
    for (genvar p = 0; p < int'(N_PORTS); p++) begin : g_cnt
        logic [CRC_W-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_accept && w_g_last && (r_grant_id == ID_W'(p))) begin
                r_cnt <= r_cnt + CRC_W'(1);
            end
        end
        assign pkt_count[p*CRC_W +: CRC_W] = r_cnt;
    end
`else
    assign pkt_count = '0;
`endif

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tid    = r_m_tid;
    assign m_crc_init    = r_crc_init;
    assign grant_active  = (r_state == ST_BUSY);
    assign grant_id      = r_grant_id;

endmodule

// File: tb/tb_crc32_stream_arbiter.sv
// ----------------------------------------------------------------------------
// tb_crc32_stream_arbiter
// Directed bench for crc32_stream_arbiter: per-port beat sources, an ordered
// expected-beat scoreboard and hand-derived cycle tables for ready/bubbles.
// ----------------------------------------------------------------------------
module tb_crc32_stream_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NP*DW-1:0]   s_axis_tdata = '0;
    logic [NP*KW-1:0]   s_axis_tkeep = '0;
    logic [NP-1:0]      s_axis_tvalid = '0;
    logic [NP-1:0]      s_axis_tlast = '0;
    logic [NP-1:0]      s_axis_tready;
    logic [NP*32-1:0]   port_crc_init = '1;
    logic [DW-1:0]      m_axis_tdata;
    logic [KW-1:0]      m_axis_tkeep;
    logic               m_axis_tvalid;
    logic               m_axis_tlast;
    logic [IW-1:0]      m_axis_tid;
    logic               m_axis_tready = 1'b1;
    logic [31:0]        m_crc_init;
    logic               grant_active;
    logic [IW-1:0]      grant_id;
    logic [NP*32-1:0]   pkt_count;

    always #5 clk = ~clk;

    crc32_stream_arbiter #(
        .N_PORTS (NP),
        .ID_W    (IW),
        .DATA_W  (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .port_crc_init (port_crc_init),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tready (m_axis_tready),
        .m_crc_init    (m_crc_init),
        .grant_active  (grant_active),
        .grant_id      (grant_id),
        .pkt_count     (pkt_count)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [1:0]  tid;
        logic [31:0] crc;
    } beat_t;

    beat_t       src_mem [NP][32];
    int          src_wr [NP];
    int          src_rd [NP];
    logic [31:0] crc_cfg [NP];
    beat_t       exp_q[$];
    int          obs_t[$];
    logic        obs_ga[$];
    int          acc_t[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    bit          mon_en = 1'b1;

    // m_axis_tready per cycle and the required s_axis_tready for the stall test.
    bit          rdy_pat [8] = '{1, 1, 1, 0, 0, 1, 1, 1};
    logic [3:0]  rdy_exp [8] = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h4, 4'h4, 4'h0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_data(input int p, input int k, input int b);
        return {16'hC0DE, 8'(p), 8'(k), 16'h0000, 8'(b), 8'h5A};
    endfunction

    function automatic beat_t mk_beat(input int p, input int k, input int b, input int n,
                                      input logic [7:0] lk);
        beat_t r;
        r.data = mk_data(p, k, b);
        r.keep = (b == n - 1) ? lk : 8'hFF;
        r.last = (b == n - 1);
        r.tid  = 2'(p);
        r.crc  = crc_cfg[p];
        return r;
    endfunction

    task automatic drive();
        beat_t b;
        for (int p = 0; p < NP; p++) begin
            port_crc_init[p*32 +: 32] = crc_cfg[p];
            b = '0;
            s_axis_tvalid[p] = (src_rd[p] < src_wr[p]);
            if (src_rd[p] < src_wr[p]) b = src_mem[p][src_rd[p]];
            s_axis_tdata[p*DW +: DW] = b.data;
            s_axis_tkeep[p*KW +: KW] = b.keep;
            s_axis_tlast[p]          = b.last;
        end
    endtask

    task automatic add_pkt(input int p, input int k, input int n, input logic [7:0] lk);
        for (int b = 0; b < n; b++) begin
            src_mem[p][src_wr[p]] = mk_beat(p, k, b, n, lk);
            src_wr[p]++;
        end
        drive();
    endtask

    task automatic exp_pkt(input int p, input int k, input int n, input logic [7:0] lk);
        for (int b = 0; b < n; b++) exp_q.push_back(mk_beat(p, k, b, n, lk));
    endtask

    task automatic clr_obs();
        obs_t.delete();
        obs_ga.delete();
        acc_t.delete();
    endtask

    // One clock: sample at negedge, then advance the sources after posedge.
    task automatic cyc(input bit rchk, input logic [3:0] rexp);
        logic [NP-1:0] hs;
        beat_t         e;
        @(negedge clk);
        if (rchk) check("s_tready", 64'(s_axis_tready), 64'(rexp));
        hs = s_axis_tvalid & s_axis_tready;
        if (mon_en && m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tid",  64'(m_axis_tid),   64'(e.tid));
                check("data", m_axis_tdata,       e.data);
                check("keep", 64'(m_axis_tkeep), 64'(e.keep));
                check("last", 64'(m_axis_tlast), 64'(e.last));
                check("crc",  64'(m_crc_init),   64'(e.crc));
            end
            obs_t.push_back(cyc_n);
            obs_ga.push_back(grant_active);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (hs[p]) begin
                src_rd[p]++;
                acc_t.push_back(cyc_n);
            end
        end
        cyc_n++;
        drive();
    endtask

    task automatic run(input int max);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && i < max) begin
            cyc(1'b0, 4'h0);
            i++;
        end
        check("drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            src_wr[p] = 0;
            src_rd[p] = 0;
        end
        exp_q.delete();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clr_obs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e3;
        for (int p = 0; p < NP; p++) crc_cfg[p] = 32'hFFFF_FFFF;

        // Reset values
        do_reset();
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata",  m_axis_tdata,       64'd0);
        check("rst_tkeep",  64'(m_axis_tkeep),  64'd0);
        check("rst_tlast",  64'(m_axis_tlast),  64'd0);
        check("rst_tid",    64'(m_axis_tid),    64'd0);
        check("rst_sready", 64'(s_axis_tready), 64'd0);
        check("rst_crc",    64'(m_crc_init),    64'hFFFF_FFFF);
        check("rst_gact",   64'(grant_active),  64'd0);
        check("rst_gid",    64'(grant_id),      64'd3);
        for (int p = 0; p < NP; p++) check("rst_cnt", 64'(pkt_count[p*32 +: 32]), 64'd0);

        // Single port, 3-beat packet
        add_pkt(0, 0, 3, 8'h0F);
        exp_pkt(0, 0, 3, 8'h0F);
        run(40);
        check("t1_nbeats",  64'(obs_t.size()), 64'd3);
        check("t1_latency", 64'(obs_t[0] - acc_t[0]), 64'd1);
        check("t1_rate",    64'(obs_t[1] - obs_t[0]), 64'd1);
        check("t1_gact_b0", 64'(obs_ga[0]), 64'd1);
        check("t1_gact_b2", 64'(obs_ga[2]), 64'd0);
        check("t1_gact_end", 64'(grant_active), 64'd0);
        check("t1_gid",     64'(grant_id), 64'd0);

        // All four ports, two 2-beat packets each: order 0,1,2,3,0,1,2,3
        do_reset();
        for (int p = 0; p < NP; p++) crc_cfg[p] = 32'(32'h1111_1111 * (p + 1));
        for (int p = 0; p < NP; p++) begin
            add_pkt(p, 0, 2, 8'hFF);
            add_pkt(p, 1, 2, 8'hFF);
        end
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++) exp_pkt(p, k, 2, 8'hFF);
        run(100);
        check("t2_nbeats", 64'(obs_t.size()), 64'd16);
        check("t2_intra",  64'(obs_t[1] - obs_t[0]), 64'd1);
        for (int j = 0; j < 7; j++) check("t2_bubble", 64'(obs_t[2*j+2] - obs_t[2*j+1]), 64'd2);

        // Port 2 with downstream stall 1,0,0,1 mid-packet
        do_reset();
        for (int p = 0; p < NP; p++) crc_cfg[p] = 32'hFFFF_FFFF;
        add_pkt(2, 0, 4, 8'h03);
        exp_pkt(2, 0, 4, 8'h03);
        for (int i = 0; i < 8; i++) begin
            m_axis_tready = rdy_pat[i];
            cyc(1'b1, rdy_exp[i]);
        end
        m_axis_tready = 1'b1;
        run(20);
        check("t3_nbeats", 64'(obs_t.size()), 64'd4);

        // Per-port seed: port 1 custom, port 3 default
        do_reset();
        crc_cfg[1] = 32'h1234_5678;
        add_pkt(1, 0, 2, 8'hFF);
        add_pkt(3, 0, 3, 8'h01);
        exp_pkt(1, 0, 2, 8'hFF);
        exp_pkt(3, 0, 3, 8'h01);
        run(60);
        check("t4_crc_hold", 64'(m_crc_init), 64'hFFFF_FFFF);
        check("t4_gid",      64'(grant_id),   64'd3);

        // Reset asserted on beat 2 of a 4-beat packet
        do_reset();
        crc_cfg[1] = 32'hFFFF_FFFF;
        mon_en = 1'b0;
        add_pkt(3, 0, 4, 8'hFF);
        repeat (3) cyc(1'b0, 4'h0);
        check("t5_pre_gact",  64'(grant_active), 64'd1);
        check("t5_pre_data",  m_axis_tdata,      mk_data(3, 0, 1));
        rst_n = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_wr[p] = 0;
            src_rd[p] = 0;
        end
        drive();
        #1;
        check("t5_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_rst_gact",   64'(grant_active),  64'd0);
        check("t5_rst_gid",    64'(grant_id),      64'd3);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        clr_obs();
        add_pkt(2, 0, 2, 8'hFF);
        add_pkt(0, 0, 2, 8'hFF);
        exp_pkt(0, 0, 2, 8'hFF);
        exp_pkt(2, 0, 2, 8'hFF);
        run(40);
        check("t5_nbeats", 64'(obs_t.size()), 64'd4);

        // Single-beat packets: 5 on port 3 (first with zero tkeep), 2 on port 0
        do_reset();
        for (int k = 0; k < 5; k++) add_pkt(3, k, 1, (k == 0) ? 8'h00 : 8'hFF);
        for (int k = 0; k < 2; k++) add_pkt(0, k, 1, 8'hA5);
        exp_pkt(0, 0, 1, 8'hA5);
        exp_pkt(3, 0, 1, 8'h00);
        exp_pkt(0, 1, 1, 8'hA5);
        for (int k = 1; k < 5; k++) exp_pkt(3, k, 1, 8'hFF);
        run(100);
        check("t6_nbeats", 64'(obs_t.size()), 64'd7);
        check("t6_bubble", 64'(obs_t[1] - obs_t[0]), 64'd2);
        check("t6_gact",   64'(grant_active), 64'd0);
`ifdef CRC32_ARB_STATS_EN
        e0 = 2;
        e3 = 5;
`else
        e0 = 0;
        e3 = 0;
`endif
        check("cnt_p0", 64'(pkt_count[0*32 +: 32]), 64'(e0));
        check("cnt_p1", 64'(pkt_count[1*32 +: 32]), 64'd0);
        check("cnt_p2", 64'(pkt_count[2*32 +: 32]), 64'd0);
        check("cnt_p3", 64'(pkt_count[3*32 +: 32]), 64'(e3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/crc32_stream_arbiter.md
Name: crc32_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one 64-bit CRC32 pipeline between N_PORTS AXI4-Stream requesters.
- Forwards whole packets, never interleaved, to the downstream CRC pipeline slave interface.
- Tags every beat with the source port ID.
- Presents the per-port CRC seed, held stable for the whole packet, on the pipeline's crc_init input.

Parameters:
- N_PORTS, 4, number of requester ports (1..16)
- ID_W, 2, width of grant/tid; must be ≥ clog2(N_PORTS), minimum 1
- DATA_W, 64, beat width in bits; KEEP_W = DATA_W/8

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  N_PORTS*DATA_W  per-port data; port p occupies slice p
- s_axis_tkeep  in  N_PORTS*KEEP_W  per-port byte enables
- s_axis_tvalid  in  N_PORTS  per-port valid
- s_axis_tlast  in  N_PORTS  per-port end of packet
- s_axis_tready  out  N_PORTS  per-port ready
- port_crc_init  in  N_PORTS*32  per-port CRC seed (normally 32'hFFFFFFFF)
- m_axis_tdata  out  DATA_W  to CRC pipeline
- m_axis_tkeep  out  KEEP_W  to CRC pipeline
- m_axis_tvalid  out  1  to CRC pipeline
- m_axis_tlast  out  1  to CRC pipeline
- m_axis_tid  out  ID_W  source port of the current beat
- m_axis_tready  in  1  from CRC pipeline
- m_crc_init  out  32  seed for the granted port
- grant_active  out  1  a packet is in progress
- grant_id  out  ID_W  currently or last granted port
- pkt_count  out  N_PORTS*32  per-port packet counters (see Optional Feature)

Behaviour:
- Reset values: all m_axis_* = 0, s_axis_tready = 0, m_crc_init = 32'hFFFFFFFF, grant_active = 0, grant_id = N_PORTS-1, pkt_count = 0. State = IDLE.
- Output stage is registered.
  - out_ready = !m_axis_tvalid || m_axis_tready.
  - Latency from accepted input beat to m_axis_tvalid is 1 cycle.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - s_axis_tready = 0.
  - If any tvalid is set, choose the first requesting port searching upward from (grant_id+1) mod N_PORTS, wrapping.
  - On that choice, register grant_id and m_crc_init = port_crc_init[grant], then go to BUSY.
- BUSY:
  - s_axis_tready[g] = out_ready for the granted port g only; all other ports see 0.
  - On an accepted beat, the output register loads data, keep, last and tid = g.
  - On an accepted beat with tlast = 1, go to IDLE.
- Throughput: one bubble cycle is inserted between consecutive packets. Within a packet the block sustains 1 beat/cycle.
- m_crc_init changes only on the IDLE→BUSY transition. It is stable from the first through the last beat of a packet, so the pipeline samples it correctly at packet start.
- Downstream stall (m_axis_tready = 0): the output register holds, s_axis_tready drops, and no beat is lost or duplicated.
- Granted requester drops tvalid mid-packet: the grant is held indefinitely, with no timeout and no preemption.
- Single-beat packet (tlast on the first beat): BUSY for exactly 1 accepted beat, then IDLE.
- Only one port requesting: it is re-granted after each bubble cycle.
- tkeep is forwarded unmodified, including all-zero tkeep.
- The s_axis_tvalid mask is sampled only in IDLE; new requests during BUSY wait for arbitration.
- rst_n asserted mid-packet: immediate return to reset values and any partial packet is discarded. The CRC pipeline shares rst_n and therefore also restarts.

Optional Feature:
- Macro CRC32_ARB_STATS_EN.
- Defined:
  - pkt_count[p] increments by 1 when port p's tlast beat is accepted.
  - 32-bit counter, wraps 32'hFFFFFFFF→0, reset to 0.
- Not defined: pkt_count is driven constant 0 and no counter flops are built.

Decomposition:
- Package crc32_arb_pkg:
  - CRC_W = 32
  - CRC_INIT_DEFAULT = 32'hFFFFFFFF
  - default N_PORTS/DATA_W
  - FSM state enum (IDLE, BUSY)
- Sub-module crc32_rr_pick: combinational rotate-priority picker.
  - Inputs: req[N_PORTS], last[ID_W].
  - Outputs: found, pick[ID_W].

Test Plan:
- Reset, then only port 0 sends 3 beats (tlast on beat 3), tready = 1 → m_axis shows the 3 beats with tid = 0, one cycle delayed. m_crc_init = port_crc_init[0] throughout. grant_active falls after beat 3.
- Ports 0–3 each hold a 2-beat packet ready simultaneously → output order is ports 0,1,2,3, never interleaved, with a 1-cycle bubble between packets. Repeat → order restarts at 0.
- Port 2 mid-packet with m_axis_tready toggling 1,0,0,1 → s_axis_tready[2] mirrors out_ready, and the beat sequence is intact without duplication.
- port_crc_init[1] = 32'h12345678, others 32'hFFFFFFFF; send port 1 then port 3 packets → m_crc_init reads 12345678 during port 1's packet and FFFFFFFF during port 3's packet.
- Assert rst_n low on beat 2 of a 4-beat packet → next cycle m_axis_tvalid = 0 and grant_active = 0. After release, port 0 is granted first.
- With CRC32_ARB_STATS_EN, send 5 packets on port 3 and 2 on port 0 → pkt_count[3] = 5, pkt_count[0] = 2, others 0. Without the macro, all counts are 0.
